writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
//  Final pipeline stage behind the memory-execute stage: aligns the 1-cycle-late
//  synchronous load data with its destination, writes the register file, and
//  serves the two decode read ports with full bypass. Flags load-use hazards so
//  decode can insert a bubble; keeps a wrapping retired-instruction count.
// PARAMETERS
//  LEN_REG      32     register/data width
//  LEN_REG_IDX  4      register index width (2**LEN_REG_IDX registers, r0 = zero)
//  LEN_OPECODE  6      opcode width
//  OPECODE_LD   6'h10  load opcode (result = memory Q)
//  OPECODE_ST   6'h11  store opcode (no register write)
//  OPECODE_NOP  6'h00  no-op (no register write)
// PORTS
//  clk          in   1            clock, all state updates on rising edge
//  rst          in   1            synchronous, active-high reset
//  in_valid     in   1            execute stage holds a valid instruction
//  in_opecode   in   LEN_OPECODE  opcode of execute-stage instruction
//  in_rd_idx    in   LEN_REG_IDX  destination index of execute-stage instruction
//  in_alu_data  in   LEN_REG      non-load result from execute stage
//  mem_q        in   LEN_REG      memory read data; valid the cycle after LD addr
//  rs_idx_a     in   LEN_REG_IDX  decode read port A index
//  rs_idx_b     in   LEN_REG_IDX  decode read port B index
//  rs_data_a    out  LEN_REG      port A data (combinational, bypassed)
//  rs_data_b    out  LEN_REG      port B data (combinational, bypassed)
//  stall        out  1            load-use hazard: decode must bubble this cycle
//  retire_count out  32           count of instructions retired from W1
// BEHAVIOUR
//  - writes = valid && opcode!=ST && opcode!=NOP && rd_idx!=0.
//  - W1 register: each edge captures w1_valid<=in_valid, w1_is_ld, w1_writes,
//    w1_rd_idx, w1_alu_data. No enable; upstream stalls by sending in_valid=0.
//  - Write data wd = w1_is_ld ? mem_q : w1_alu_data; regfile[w1_rd_idx]<=wd at
//    the edge ending the W1 cycle when w1_writes. Load result latency: LD in
//    execute at cycle N -> mem_q sampled cycle N+1 -> readable from file N+2.
//  - Read port (each independent), priority high to low:
//    idx==0 -> 0; execute match (in writes && in_rd_idx==idx): non-LD ->
//    in_alu_data, LD -> regfile value (don't-care) with stall=1; W1 match
//    (w1_writes && w1_rd_idx==idx) -> wd (incl. mem_q); else regfile[idx].
//  - stall = in_valid && opcode==LD && in_rd_idx!=0 && (in_rd_idx==rs_idx_a ||
//    in_rd_idx==rs_idx_b). Purely combinational; port match not qualified by use.
//  - Writes to r0 discarded; r0 always reads 0, never stalls.
//  - retire_count +1 per edge with w1_valid (ST/NOP included); wraps FFFFFFFF->0.
//  - Reset (rst=1 at edge): w1_valid=0, all W1 fields 0, every register 0,
//    retire_count=0; an in-flight W1 write in that cycle is dropped. Outputs
//    after reset: rs_data_* = 0 for any idx absent execute forwarding,
//    stall follows inputs, retire_count=0.
//  - Same-cycle write and read of same idx: bypass returns new value.
// TESTING
//  1 rst; ALU r3<=0x1234 in_valid 1 cycle -> cycle 0 rs_a(3)=0x1234 via
//    execute fwd, cycle 1 via W1, cycle 2+ from file; retire_count=1.
//  2 LD r5 at cycle N, mem_q=0xDEADBEEF at N+1, rs_a=5 at N -> stall=1 at N,
//    N+1 rs_a=0xDEADBEEF (W1 bypass, stall=0), N+2 from file.
//  3 ST and NOP with rd=7, then ALU r0<=0xFFFF -> r7 and r0 read 0, no stall,
//    retire_count +3.
//  4 Back-to-back ALU r2<=1 then r2<=2, read r2 each cycle -> 1, 2, 2 (younger
//    execute value beats W1); port B on r2 same results.
//  5 Preload retire_count to 0xFFFFFFFE via 2^32-2 retirements (or force) ->
//    two more valid -> 0xFFFFFFFF, 0x00000000.
//  6 rst asserted while W1 holds ALU r4<=0x55 -> r4 reads 0 after, count=0.

Source files
------------

// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
//
// Last pipeline stage after memory-execute. One register stage (W1) holds the
// retiring instruction for the cycle in which its synchronous load data shows
// up on mem_q. At the end of that cycle the result is written into the
// register file. Two decode read ports see the file through a full bypass
// network. A load-use hazard flag tells decode to insert a bubble. A wrapping
// counter tracks retired instructions.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid            execute stage holds a valid instruction
//   in_opecode          opcode of the execute-stage instruction
//   in_rd_idx           destination index of the execute-stage instruction
//   in_alu_data         non-load result from execute
//   mem_q               memory read data, valid the cycle after the LD address
//   rs_idx_a/b          decode read indices
//   rs_data_a/b         bypassed read data (combinational)
//   stall               load-use hazard against either read index
//   retire_count        wrapping count of instructions leaving W1
//
// Handshake: in_valid is a plain qualifier with no ready. Every edge accepts
// whatever execute presents. Upstream stalls by driving in_valid=0, which
// retires a bubble and leaves the register file untouched.
// ---------------------------------------------------------------------------
module writeback_regfile #(
    parameter int unsigned                LEN_REG     = 32,
    parameter int unsigned                LEN_REG_IDX = 4,
    parameter int unsigned                LEN_OPECODE = 6,
    parameter logic [LEN_OPECODE-1:0]     OPECODE_LD  = 6'h10,
    parameter logic [LEN_OPECODE-1:0]     OPECODE_ST  = 6'h11,
    parameter logic [LEN_OPECODE-1:0]     OPECODE_NOP = 6'h00
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [LEN_OPECODE-1:0] in_opecode,
    input  logic [LEN_REG_IDX-1:0] in_rd_idx,
    input  logic [LEN_REG-1:0]     in_alu_data,
    input  logic [LEN_REG-1:0]     mem_q,
    input  logic [LEN_REG_IDX-1:0] rs_idx_a,
    input  logic [LEN_REG_IDX-1:0] rs_idx_b,
    output logic [LEN_REG-1:0]     rs_data_a,
    output logic [LEN_REG-1:0]     rs_data_b,
    output logic                   stall,
    output logic [31:0]            retire_count
);

    localparam int unsigned NUM_REGS = 2 ** LEN_REG_IDX;

    // Execute-stage decode
    logic in_is_ld;
    logic in_writes;

    assign in_is_ld  = in_valid && (in_opecode == OPECODE_LD);
    assign in_writes = in_valid && (in_opecode != OPECODE_ST) &&
                       (in_opecode != OPECODE_NOP) && (in_rd_idx != '0);

    // W1 stage and architectural state
    logic                   w1_valid_q,    w1_valid_d;
    logic                   w1_is_ld_q,    w1_is_ld_d;
    logic                   w1_writes_q,   w1_writes_d;
    logic [LEN_REG_IDX-1:0] w1_rd_idx_q,   w1_rd_idx_d;
    logic [LEN_REG-1:0]     w1_alu_data_q, w1_alu_data_d;
    logic [LEN_REG-1:0]     regs_q [NUM_REGS];
    logic [LEN_REG-1:0]     regs_d [NUM_REGS];
    logic [31:0]            retire_count_q, retire_count_d;

    // Write data for the instruction in W1. Load data arrives this cycle.
    logic [LEN_REG-1:0]     wd;

    always_comb begin
        w1_valid_d    = in_valid;
        w1_is_ld_d    = in_is_ld;
        w1_writes_d   = in_writes;
        w1_rd_idx_d   = in_rd_idx;
        w1_alu_data_d = in_alu_data;

        wd = w1_is_ld_q ? mem_q : w1_alu_data_q;

        regs_d = regs_q;
        if (w1_writes_q) begin
            regs_d[w1_rd_idx_q] = wd;
        end
        // r0 is hardwired to zero. w1_writes already excludes it; this keeps
        // the storage itself constant.
        regs_d[0] = '0;

        retire_count_d = retire_count_q;
        if (w1_valid_q) begin
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w1_valid_q     <= 1'b0;
            w1_is_ld_q     <= 1'b0;
            w1_writes_q    <= 1'b0;
            w1_rd_idx_q    <= '0;
            w1_alu_data_q  <= '0;
            retire_count_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            w1_valid_q     <= w1_valid_d;
            w1_is_ld_q     <= w1_is_ld_d;
            w1_writes_q    <= w1_writes_d;
            w1_rd_idx_q    <= w1_rd_idx_d;
            w1_alu_data_q  <= w1_alu_data_d;
            retire_count_q <= retire_count_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports. Youngest producer wins: execute beats W1, and W1 beats the
    // file. A load still in execute has no data yet. It returns the stale
    // file value, and stall tells decode to throw that value away.
    logic [LEN_REG_IDX-1:0] rd_port_idx  [2];
    logic [LEN_REG-1:0]     rd_port_data [2];

    assign rd_port_idx[0] = rs_idx_a;
    assign rd_port_idx[1] = rs_idx_b;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_port_data[p] = regs_q[rd_port_idx[p]];
            if (rd_port_idx[p] == '0) begin
                rd_port_data[p] = '0;
            end else if (in_writes && (in_rd_idx == rd_port_idx[p])) begin
                rd_port_data[p] = in_is_ld ? regs_q[rd_port_idx[p]] : in_alu_data;
            end else if (w1_writes_q && (w1_rd_idx_q == rd_port_idx[p])) begin
                rd_port_data[p] = wd;
            end
        end
    end

    assign rs_data_a = rd_port_data[0];
    assign rs_data_b = rd_port_data[1];

    // Port indices are compared whether or not decode actually uses them.
    // An occasional spurious bubble is cheaper than decoding operand usage.
    assign stall = in_is_ld && (in_rd_idx != '0) &&
                   ((in_rd_idx == rs_idx_a) || (in_rd_idx == rs_idx_b));

    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// ---------------------------------------------------------------------------
// tb_writeback_regfile
//
// Directed scenarios plus a short random ALU/store run against a small
// reference model. Inputs change on the falling edge. Outputs are sampled 1ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_writeback_regfile;

    localparam logic [5:0] OP_ALU = 6'h01;
    localparam logic [5:0] OP_LD  = 6'h10;
    localparam logic [5:0] OP_ST  = 6'h11;
    localparam logic [5:0] OP_NOP = 6'h00;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [5:0]  in_opecode;
    logic [3:0]  in_rd_idx;
    logic [31:0] in_alu_data;
    logic [31:0] mem_q;
    logic [3:0]  rs_idx_a;
    logic [3:0]  rs_idx_b;
    logic [31:0] rs_data_a;
    logic [31:0] rs_data_b;
    logic        stall;
    logic [31:0] retire_count;

    logic [31:0] exp_q [$];
    logic [31:0] exp;
    int          checks;
    int          errors;
    logic [31:0] retired;

    writeback_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_opecode   (in_opecode),
        .in_rd_idx    (in_rd_idx),
        .in_alu_data  (in_alu_data),
        .mem_q        (mem_q),
        .rs_idx_a     (rs_idx_a),
        .rs_idx_b     (rs_idx_b),
        .rs_data_a    (rs_data_a),
        .rs_data_b    (rs_data_b),
        .stall        (stall),
        .retire_count (retire_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [5:0] op,
                         input logic [3:0] rd, input logic [31:0] d);
        in_valid    = v;
        in_opecode  = op;
        in_rd_idx   = rd;
        in_alu_data = d;
    endtask

    task automatic idle();
        drive(1'b0, OP_NOP, 4'd0, 32'd0);
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        idle();
        mem_q = 32'd0;
        rs_idx_a = 4'd3;
        rs_idx_b = 4'd9;
        step();
        step();
        rst = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (retire_count !== exp) begin errors++; $display("FAIL reset_count: got %h expected %h", retire_count, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL reset_rs_a: got %h expected %h", rs_data_a, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rs_data_b !== exp) begin errors++; $display("FAIL reset_rs_b: got %h expected %h", rs_data_b, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, stall} !== exp) begin errors++; $display("FAIL reset_stall: got %b expected %h", stall, exp); end
        retired = 32'd0;
    endtask

    task automatic test_alu_forward();
        rs_idx_a = 4'd3;
        drive(1'b1, OP_ALU, 4'd3, 32'h1234);
        exp_q.push_back(32'h1234);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL alu_exec_fwd: got %h expected %h", rs_data_a, exp); end
        step();
        idle();
        exp_q.push_back(32'h1234);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL alu_w1_fwd: got %h expected %h", rs_data_a, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_count !== exp) begin errors++; $display("FAIL alu_count_w1: got %h expected %h", retire_count, exp); end
        step();
        retired = retired + 32'd1;
        exp_q.push_back(32'h1234);
        exp_q.push_back(retired);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL alu_file: got %h expected %h", rs_data_a, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_count !== exp) begin errors++; $display("FAIL alu_count: got %h expected %h", retire_count, exp); end
    endtask

    task automatic test_load_use();
        rs_idx_a = 4'd5;
        rs_idx_b = 4'd0;
        drive(1'b1, OP_LD, 4'd5, 32'h0BAD_0BAD);
        exp_q.push_back(32'd1);
        #1;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, stall} !== exp) begin errors++; $display("FAIL ld_stall: got %b expected %h", stall, exp); end
        step();
        idle();
        mem_q = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL ld_w1_fwd: got %h expected %h", rs_data_a, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, stall} !== exp) begin errors++; $display("FAIL ld_no_stall: got %b expected %h", stall, exp); end
        step();
        mem_q = 32'h0;
        retired = retired + 32'd1;
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(retired);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL ld_file: got %h expected %h", rs_data_a, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_count !== exp) begin errors++; $display("FAIL ld_count: got %h expected %h", retire_count, exp); end
    endtask

    task automatic test_stall_ports();
        // Port B match alone stalls; a load to r0 never stalls.
        rs_idx_a = 4'd1;
        rs_idx_b = 4'd6;
        drive(1'b1, OP_LD, 4'd6, 32'd0);
        exp_q.push_back(32'd1);
        #1;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, stall} !== exp) begin errors++; $display("FAIL stall_port_b: got %b expected %h", stall, exp); end
        step();
        mem_q = 32'h6666_0006;
        rs_idx_a = 4'd0;
        rs_idx_b = 4'd0;
        drive(1'b1, OP_LD, 4'd0, 32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h6666_0006);
        #1;
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, stall} !== exp) begin errors++; $display("FAIL stall_r0: got %b expected %h", stall, exp); end
        rs_idx_b = 4'd6;
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_b !== exp) begin errors++; $display("FAIL ld_port_b_w1: got %h expected %h", rs_data_b, exp); end
        step();
        idle();
        mem_q = 32'd0;
        step();
        retired = retired + 32'd2;
    endtask

    task automatic test_st_nop_r0();
        logic [31:0] base;
        base = retired;
        rs_idx_a = 4'd7;
        rs_idx_b = 4'd0;
        drive(1'b1, OP_ST, 4'd7, 32'hAAAA);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL st_no_fwd: got %h expected %h", rs_data_a, exp); end
        exp = exp_q.pop_front(); checks++;
        if ({31'd0, stall} !== exp) begin errors++; $display("FAIL st_no_stall: got %b expected %h", stall, exp); end
        step();
        drive(1'b1, OP_NOP, 4'd7, 32'hBBBB);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL nop_no_fwd: got %h expected %h", rs_data_a, exp); end
        step();
        rs_idx_a = 4'd0;
        rs_idx_b = 4'd7;
        drive(1'b1, OP_ALU, 4'd0, 32'hFFFF);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL r0_exec: got %h expected %h", rs_data_a, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rs_data_b !== exp) begin errors++; $display("FAIL r7_after_st: got %h expected %h", rs_data_b, exp); end
        step();
        idle();
        step();
        retired = base + 32'd3;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(retired);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL r0_file: got %h expected %h", rs_data_a, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rs_data_b !== exp) begin errors++; $display("FAIL r7_file: got %h expected %h", rs_data_b, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_count !== exp) begin errors++; $display("FAIL st_nop_count: got %h expected %h", retire_count, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [4];
        seq[0] = 32'd1; seq[1] = 32'd2; seq[2] = 32'd2; seq[3] = 32'd2;
        rs_idx_a = 4'd2;
        rs_idx_b = 4'd2;
        for (int c = 0; c < 4; c++) begin
            if (c < 2) drive(1'b1, OP_ALU, 4'd2, seq[c]);
            else       idle();
            exp_q.push_back(seq[c]);
            exp_q.push_back(seq[c]);
            #1;
            exp = exp_q.pop_front(); checks++;
            if (rs_data_a !== exp) begin errors++; $display("FAIL b2b_a cycle %0d: got %h expected %h", c, rs_data_a, exp); end
            exp = exp_q.pop_front(); checks++;
            if (rs_data_b !== exp) begin errors++; $display("FAIL b2b_b cycle %0d: got %h expected %h", c, rs_data_b, exp); end
            step();
        end
        retired = retired + 32'd2;
    endtask

    task automatic test_retire_wrap();
        // W1 is idle here, so the preloaded count holds until new retirements.
        force dut.retire_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_count_q;
        exp_q.push_back(32'hFFFF_FFFE);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (retire_count !== exp) begin errors++; $display("FAIL wrap_preload: got %h expected %h", retire_count, exp); end
        drive(1'b1, OP_ALU, 4'd1, 32'h11);
        step();
        drive(1'b1, OP_ALU, 4'd1, 32'h22);
        step();
        idle();
        exp_q.push_back(32'hFFFF_FFFF);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (retire_count !== exp) begin errors++; $display("FAIL wrap_max: got %h expected %h", retire_count, exp); end
        step();
        exp_q.push_back(32'h0000_0000);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (retire_count !== exp) begin errors++; $display("FAIL wrap_zero: got %h expected %h", retire_count, exp); end
        retired = 32'd0;
    endtask

    task automatic test_reset_drop();
        rs_idx_a = 4'd4;
        rs_idx_b = 4'd2;
        drive(1'b1, OP_ALU, 4'd4, 32'h55);
        step();
        idle();
        rst = 1'b1;
        exp_q.push_back(32'h55);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL rstdrop_w1: got %h expected %h", rs_data_a, exp); end
        step();
        rst = 1'b0;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL rstdrop_r4: got %h expected %h", rs_data_a, exp); end
        exp = exp_q.pop_front(); checks++;
        if (rs_data_b !== exp) begin errors++; $display("FAIL rstdrop_r2: got %h expected %h", rs_data_b, exp); end
        exp = exp_q.pop_front(); checks++;
        if (retire_count !== exp) begin errors++; $display("FAIL rstdrop_count: got %h expected %h", retire_count, exp); end
        step();
        exp_q.push_back(32'd0);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (rs_data_a !== exp) begin errors++; $display("FAIL rstdrop_r4_late: got %h expected %h", rs_data_a, exp); end
        retired = 32'd0;
    endtask

    task automatic test_random();
        logic [31:0] model [16];
        logic        m_w1_w;
        logic [3:0]  m_w1_rd;
        logic [31:0] m_w1_data;
        logic        v, w;
        logic [5:0]  op;
        logic [3:0]  rd;
        logic [31:0] d;
        logic [3:0]  ra, rb;
        for (int i = 0; i < 16; i++) model[i] = 32'd0;
        m_w1_w = 1'b0; m_w1_rd = 4'd0; m_w1_data = 32'd0;
        for (int c = 0; c < 60; c++) begin
            case ($urandom_range(0, 4))
                0:       begin v = 1'b0; op = OP_ALU; end
                1:       begin v = 1'b1; op = OP_ST;  end
                2:       begin v = 1'b1; op = OP_NOP; end
                default: begin v = 1'b1; op = OP_ALU; end
            endcase
            rd = 4'($urandom_range(0, 15));
            d  = $urandom;
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? rd : 4'($urandom_range(0, 15));
            w  = v && (op == OP_ALU) && (rd != 4'd0);
            drive(v, op, rd, d);
            rs_idx_a = ra;
            rs_idx_b = rb;
            if (ra == 4'd0)                      exp_q.push_back(32'd0);
            else if (w && rd == ra)              exp_q.push_back(d);
            else if (m_w1_w && m_w1_rd == ra)    exp_q.push_back(m_w1_data);
            else                                 exp_q.push_back(model[ra]);
            if (rb == 4'd0)                      exp_q.push_back(32'd0);
            else if (w && rd == rb)              exp_q.push_back(d);
            else if (m_w1_w && m_w1_rd == rb)    exp_q.push_back(m_w1_data);
            else                                 exp_q.push_back(model[rb]);
            #1;
            exp = exp_q.pop_front(); checks++;
            if (rs_data_a !== exp) begin errors++; $display("FAIL rand_a cycle %0d idx %0d: got %h expected %h", c, ra, rs_data_a, exp); end
            exp = exp_q.pop_front(); checks++;
            if (rs_data_b !== exp) begin errors++; $display("FAIL rand_b cycle %0d idx %0d: got %h expected %h", c, rb, rs_data_b, exp); end
            if (stall !== 1'b0) begin errors++; $display("FAIL rand_stall cycle %0d: got %b expected 0", c, stall); end
            checks++;
            if (m_w1_w) model[m_w1_rd] = m_w1_data;
            m_w1_w = w; m_w1_rd = rd; m_w1_data = d;
            if (v) retired = retired + 32'd1;
            step();
        end
        idle();
        step();
        if (m_w1_w) model[m_w1_rd] = m_w1_data;
        exp_q.push_back(retired);
        #1;
        exp = exp_q.pop_front(); checks++;
        if (retire_count !== exp) begin errors++; $display("FAIL rand_count: got %h expected %h", retire_count, exp); end
        for (int i = 0; i < 16; i++) begin
            rs_idx_a = 4'(i);
            exp_q.push_back(model[i]);
            #1;
            exp = exp_q.pop_front(); checks++;
            if (rs_data_a !== exp) begin errors++; $display("FAIL rand_sweep r%0d: got %h expected %h", i, rs_data_a, exp); end
        end
    endtask

    // Sequence and final report
    initial begin
        checks = 0;
        errors = 0;
        retired = 32'd0;
        rst = 1'b1;
        idle();
        mem_q = 32'd0;
        rs_idx_a = 4'd0;
        rs_idx_b = 4'd0;
        @(negedge clk);
        test_reset();
        test_alu_forward();
        step();
        test_load_use();
        step();
        test_stall_ports();
        test_st_nop_r0();
        test_back_to_back();
        step();
        test_retire_wrap();
        step();
        test_reset_drop();
        step();
        test_random();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
